memdev_mc: RTL and testbench

- Parametrised successor of the single-device memory-mapped bridge. Sits between the MIPS data-memory port and RAM plus NCH streaming devices.
- Forwards ordinary accesses to RAM. Decodes device accesses (address bit 31 set) per channel.
- Adds per-channel RX FIFOs with autonomous prefetch, a per-channel TX send state machine, sticky error flags and an optional blocking mode.

---
 rtl/memdev_pkg.sv | 43 ++++
 rtl/memdev_rx_fifo.sv | 60 ++++++
 rtl/memdev_mc.sv | 174 +++++++++++++++++
 tb/tb_memdev_mc.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memdev_pkg.sv
// Shared constants for the multi-channel memory/device bridge: register offsets,
// CTRL/STATUS bit positions and the TX state encoding.
package memdev_pkg;

    localparam logic [2:0] OFS_DATA = 3'h0;
    localparam logic [2:0] OFS_CTRL = 3'h4;

    localparam int CTRL_SEND = 17;
    localparam int CTRL_EOP  = 20;

    localparam int ST_RX_NE   = 16;
    localparam int ST_TX_IDLE = 18;
    localparam int ST_EOP     = 19;
    localparam int ST_UNDER   = 20;
    localparam int ST_OVER    = 21;
    localparam int ST_CNT_LSB = 24;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

    function automatic logic [31:0] status_word(
        input logic [7:0] cnt,
        input logic       rx_ne,
        input logic       tx_idle,
        input logic       head_eop,
        input logic       under,
        input logic       over
    );
        logic [31:0] s;
        s                         = '0;
        s[ST_RX_NE]               = rx_ne;
        s[ST_TX_IDLE]             = tx_idle;
        s[ST_EOP]                 = head_eop;
        s[ST_UNDER]               = under;
        s[ST_OVER]                = over;
        s[ST_CNT_LSB +: 8]        = cnt;
        return s;
    endfunction

endpackage

// File: rtl/memdev_rx_fifo.sv
// Per-channel receive FIFO of {eop, data} entries with a registered occupancy count.
module memdev_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [32:0]              i_din,
    input  logic                     i_pop,
    output logic [32:0]              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    import memdev_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/memdev_mc.sv
// Bridge between the CPU data port, RAM and NCH streaming devices with RX prefetch
// FIFOs, per-channel TX handshake, sticky error flags and optional CPU stalling.
module memdev_mc
    import memdev_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CH_LSB   = 4,
    parameter int DEPTH    = 4,
    parameter int BLOCKING = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_a_read,
    input  logic [31:0]       i_a_read_reg,
    input  logic [31:0]       i_d_write,
    input  logic [1:0]        i_w,
    input  logic [1:0]        i_r,
    output logic [31:0]       o_d_read,
    output logic              o_dmem_wait,
    input  logic [31:0]       i_ram_dout,
    input  logic              i_ram_wait,
    output logic [1:0]        o_ram_w,
    output logic [1:0]        o_ram_r,
    output logic [31:0]       o_ram_addr,
    output logic [31:0]       o_ram_din,
    input  logic [NCH*32-1:0] i_dev_dout,
    input  logic [NCH-1:0]    i_dev_rdyr,
    input  logic [NCH-1:0]    i_dev_rcv_eop,
    input  logic [NCH-1:0]    i_dev_rdyw,
    output logic [NCH-1:0]    o_dev_r,
    output logic [NCH-1:0]    o_dev_w,
    output logic [NCH-1:0]    o_dev_send_eop,
    output logic [31:0]       o_dev_din
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    logic           w_dsel;
    logic           w_is_ctrl;
    logic           w_ch_ok;
    logic           w_rd;
    logic           w_wr;
    logic           w_send;
    logic           w_stall;
    logic           w_go;
    logic [CHW-1:0] w_ch;
    logic           w_unused;

    logic [32:0]    w_head   [NCH];
    logic [CW-1:0]  w_count  [NCH];
    logic [31:0]    w_txdata [NCH];
    logic [NCH-1:0] w_full;
    logic [NCH-1:0] w_empty;
    logic [NCH-1:0] w_pop;
    logic [NCH-1:0] w_txidle;
    logic [NCH-1:0] w_under;
    logic [NCH-1:0] w_over;

    logic           w_sel_empty;
    logic           w_sel_busy;
    logic [31:0]    w_sel_head;
    logic [31:0]    w_sel_status;
    logic [31:0]    w_sel_txdata;
    logic [31:0]    r_rd_buf;

    assign w_dsel    = i_a_read[31];
    assign w_ch      = i_a_read[CH_LSB +: CHW];
    assign w_is_ctrl = (i_a_read[2] == OFS_CTRL[2]);
    assign w_ch_ok   = (32'(w_ch) < 32'(NCH));
    assign w_rd      = w_dsel && (|i_r) && w_ch_ok;
    assign w_wr      = w_dsel && (|i_w) && w_ch_ok;
    assign w_send    = w_wr && w_is_ctrl && i_d_write[CTRL_SEND];
    assign w_unused  = ^i_a_read_reg[30:0];

    assign o_ram_addr = i_a_read;
    assign o_ram_din  = i_d_write;
    assign o_ram_w    = w_dsel ? 2'b00 : i_w;
    assign o_ram_r    = w_dsel ? 2'b00 : i_r;
    assign o_d_read   = i_a_read_reg[31] ? r_rd_buf : i_ram_dout;
    assign o_dev_din  = w_sel_txdata;

    // An out-of-range channel selects nothing: it reads as empty with zero status.
    always_comb begin
        w_sel_empty  = 1'b1;
        w_sel_busy   = 1'b0;
        w_sel_head   = '0;
        w_sel_status = '0;
        w_sel_txdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_ch_ok && (int'(w_ch) == c)) begin
                w_sel_empty  = w_empty[c];
                w_sel_busy   = !w_txidle[c];
                w_sel_head   = w_head[c][31:0];
                w_sel_txdata = w_txdata[c];
                w_sel_status = status_word(8'(w_count[c]), !w_empty[c], w_txidle[c],
                                           w_head[c][32] && !w_empty[c], w_under[c], w_over[c]);
            end
        end
    end

    assign w_stall     = (BLOCKING != 0) &&
                         ((w_rd && !w_is_ctrl && w_sel_empty) || (w_send && w_sel_busy));
    assign o_dmem_wait = (!i_a_read_reg[31] && i_ram_wait) || w_stall;
    assign w_go        = !o_dmem_wait;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_buf <= '0;
        end else if (w_go && w_dsel && (|i_r)) begin
            r_rd_buf <= w_is_ctrl ? w_sel_status : (w_sel_empty ? 32'h0 : w_sel_head);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic      w_here;
        tx_state_e r_state;
        logic [31:0] r_data;
        logic      r_under;
        logic      r_over;

        assign w_here            = w_ch_ok && (int'(w_ch) == c);
        assign o_dev_r[c]        = !i_reset && i_dev_rdyr[c] && !w_full[c];
        assign w_pop[c]          = w_go && w_here && w_rd && !w_is_ctrl;
        assign o_dev_w[c]        = !i_reset && w_go && w_here && w_send && (r_state == TX_IDLE);
        assign o_dev_send_eop[c] = o_dev_w[c] && i_d_write[CTRL_EOP];
        assign w_txidle[c]       = (r_state == TX_IDLE);
        assign w_txdata[c]       = r_data;
        assign w_under[c]        = r_under;
        assign w_over[c]         = r_over;

        memdev_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_push  (o_dev_r[c]),
            .i_din   ({i_dev_rcv_eop[c], i_dev_dout[32*c +: 32]}),
            .i_pop   (w_pop[c]),
            .o_head  (w_head[c]),
            .o_count (w_count[c]),
            .o_full  (w_full[c]),
            .o_empty (w_empty[c])
        );

        // Error flags can only be set when the access is not stalled, so in blocking
        // mode the stall itself keeps underrun/overrun from ever being raised.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_state <= TX_IDLE;
                r_data  <= '0;
                r_under <= 1'b0;
                r_over  <= 1'b0;
            end else begin
                if (w_go && w_here && w_wr && !w_is_ctrl) begin
                    r_data <= i_d_write;
                end
                case (r_state)
                    TX_IDLE: if (o_dev_w[c]) r_state <= TX_WAIT;
                    TX_WAIT: if (i_dev_rdyw[c]) r_state <= TX_IDLE;
                    default: r_state <= TX_IDLE;
                endcase
                if (w_go && w_here && w_rd && w_is_ctrl) begin
                    r_under <= 1'b0;
                    r_over  <= 1'b0;
                end
                if (w_go && w_here && w_rd && !w_is_ctrl && w_empty[c]) begin
                    r_under <= 1'b1;
                end
                if (w_go && w_here && w_send && (r_state == TX_WAIT)) begin
                    r_over <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memdev_mc.sv
// Self-checking bench for memdev_mc: a non-blocking instance plus a BLOCKING=1 instance
// sharing the same stimulus, with read data checked through an expected-value queue.
module tb_memdev_mc;

    localparam logic [31:0] CH0_DATA = 32'h8000_0000;
    localparam logic [31:0] CH0_CTRL = 32'h8000_0004;
    localparam logic [31:0] CH1_DATA = 32'h8000_0010;
    localparam logic [31:0] CH1_CTRL = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_read, a_read_reg, d_write, ram_dout;
    logic [1:0]  w, r;
    logic        ram_wait;
    logic [31:0] dout0;
    logic        rdyr0;
    logic [1:0]  dev_rdyw;
    logic [63:0] dev_dout;
    logic [1:0]  dev_rdyr, dev_rcv_eop;

    logic [31:0] d_read, ram_addr, ram_din, dev_din;
    logic        dmem_wait;
    logic [1:0]  ram_w, ram_r, dev_r, dev_w, dev_send_eop;

    logic [31:0] blk_d_read, blk_ram_addr, blk_ram_din, blk_dev_din;
    logic        blk_wait;
    logic [1:0]  blk_ram_w, blk_ram_r, blk_dev_r, blk_dev_w, blk_dev_send_eop;

    logic [31:0] feed_words [32];
    logic        feed_eop   [32];
    int          feed_n   = 0;
    int          feed_idx = 0;

    int          r1_pulses = 0;
    int          w_pulses  = 0;
    int          rst_act   = 0;
    int          checks    = 0;
    int          failures  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ram_model;

    always #5 clk = ~clk;

    // Channel 1 behaves as a device with a scripted word list; channel 0 is driven by hand.
    always_comb begin
        dev_rdyr    = {feed_idx < feed_n, rdyr0};
        dev_dout    = {(feed_idx < feed_n) ? feed_words[feed_idx[4:0]] : 32'h0, dout0};
        dev_rcv_eop = {(feed_idx < feed_n) ? feed_eop[feed_idx[4:0]] : 1'b0, 1'b0};
    end

    always @(posedge clk) begin
        if (dev_r[1]) begin
            r1_pulses <= r1_pulses + 1;
            feed_idx  <= feed_idx + 1;
        end
        if (|dev_w) w_pulses <= w_pulses + 1;
        if (reset && (|dev_r || |dev_w || |blk_dev_r || |blk_dev_w)) rst_act <= rst_act + 1;
    end

    memdev_mc #(.NCH(2), .CH_LSB(4), .DEPTH(4), .BLOCKING(0)) dut (
        .i_clk(clk), .i_reset(reset), .i_a_read(a_read), .i_a_read_reg(a_read_reg),
        .i_d_write(d_write), .i_w(w), .i_r(r), .o_d_read(d_read), .o_dmem_wait(dmem_wait),
        .i_ram_dout(ram_dout), .i_ram_wait(ram_wait), .o_ram_w(ram_w), .o_ram_r(ram_r),
        .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_dev_dout(dev_dout),
        .i_dev_rdyr(dev_rdyr), .i_dev_rcv_eop(dev_rcv_eop), .i_dev_rdyw(dev_rdyw),
        .o_dev_r(dev_r), .o_dev_w(dev_w), .o_dev_send_eop(dev_send_eop), .o_dev_din(dev_din)
    );

    memdev_mc #(.NCH(2), .CH_LSB(4), .DEPTH(4), .BLOCKING(1)) u_blk (
        .i_clk(clk), .i_reset(reset), .i_a_read(a_read), .i_a_read_reg(a_read_reg),
        .i_d_write(d_write), .i_w(w), .i_r(r), .o_d_read(blk_d_read), .o_dmem_wait(blk_wait),
        .i_ram_dout(ram_dout), .i_ram_wait(ram_wait), .o_ram_w(blk_ram_w), .o_ram_r(blk_ram_r),
        .o_ram_addr(blk_ram_addr), .o_ram_din(blk_ram_din), .i_dev_dout(dev_dout),
        .i_dev_rdyr(dev_rdyr), .i_dev_rcv_eop(dev_rcv_eop), .i_dev_rdyw(dev_rdyw),
        .o_dev_r(blk_dev_r), .o_dev_w(blk_dev_w), .o_dev_send_eop(blk_dev_send_eop),
        .o_dev_din(blk_dev_din)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        w = 2'b00; r = 2'b00; a_read = 32'h0; a_read_reg = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        a_read = addr; r = 2'b01;
        tick();
        r = 2'b00; a_read_reg = addr; a_read = 32'h0;
        #1 data = d_read;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        a_read = addr; d_write = data; w = 2'b11;
        tick();
        w = 2'b00; a_read = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        do_reset();
        exp_q.push_back(32'h0004_0000);
        exp_q.push_back(32'h0004_0000);
        bus_read(CH0_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL reset_status_ch0 got=%h exp=%h", got, exp); end
        bus_read(CH1_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL reset_status_ch1 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_ram();
        logic [31:0] exp;
        a_read = 32'h100; d_write = 32'h1234; w = 2'b11; #1;
        checks++;
        if ({ram_w, ram_r, dev_w, dev_r} !== {2'b11, 2'b00, 2'b00, 2'b00} || ram_addr !== 32'h100 || ram_din !== 32'h1234) begin
            failures++; $display("[TB] FAIL ram_write ram_w=%b addr=%h din=%h dev_w=%b exp ram_w=11 addr=100 din=1234", ram_w, ram_addr, ram_din, dev_w);
        end
        tick();
        ram_model = 32'h1234;
        w = 2'b00; r = 2'b11; #1;
        checks++;
        if (ram_r !== 2'b11 || ram_w !== 2'b00) begin failures++; $display("[TB] FAIL ram_read_strobe ram_r=%b ram_w=%b exp 11/00", ram_r, ram_w); end
        exp_q.push_back(ram_model);
        tick();
        r = 2'b00; a_read_reg = 32'h100; a_read = 32'h0; ram_dout = ram_model; ram_wait = 1'b1; #1;
        exp = exp_q.pop_front();
        checks++;
        if (d_read !== exp || dmem_wait !== 1'b1) begin failures++; $display("[TB] FAIL ram_read_wait d_read=%h wait=%b exp %h/1", d_read, dmem_wait, exp); end
        ram_wait = 1'b0; #1;
        checks++;
        if (dmem_wait !== 1'b0) begin failures++; $display("[TB] FAIL ram_wait_release wait=%b exp 0", dmem_wait); end
        tick();
    endtask

    task automatic test_rx_prefetch();
        logic [31:0] got, exp;
        int base;
        base = r1_pulses;
        for (int i = 0; i < 6; i++) begin feed_words[i] = 32'hA0 + 32'(i); feed_eop[i] = 1'b0; end
        feed_n = 6;
        repeat (8) tick();
        checks++;
        if (r1_pulses - base !== 4) begin failures++; $display("[TB] FAIL prefetch_pulses got=%0d exp=4", r1_pulses - base); end
        exp_q.push_back(32'h0405_0000);
        bus_read(CH1_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL prefetch_status got=%h exp=%h", got, exp); end
        for (int i = 0; i < 6; i++) exp_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            bus_read(CH1_DATA, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("[TB] FAIL prefetch_data%0d got=%h exp=%h", i, got, exp); end
        end
        checks++;
        if (r1_pulses - base !== 6) begin failures++; $display("[TB] FAIL prefetch_resume got=%0d exp=6", r1_pulses - base); end
    endtask

    task automatic test_eop_wrap();
        logic [31:0] got, exp;
        for (int i = 0; i < 6; i++) begin feed_words[6+i] = 32'hB0 + 32'(i); feed_eop[6+i] = (i == 2); end
        feed_n = 12;
        repeat (6) tick();
        exp_q.push_back(32'h0405_0000);
        exp_q.push_back(32'hB0);
        exp_q.push_back(32'hB1);
        exp_q.push_back(32'h040D_0000);
        exp_q.push_back(32'hB2);
        exp_q.push_back(32'h0305_0000);
        exp_q.push_back(32'hB3);
        exp_q.push_back(32'hB4);
        exp_q.push_back(32'hB5);
        exp_q.push_back(32'h0004_0000);
        for (int i = 0; i < 10; i++) begin
            bus_read((i == 0 || i == 3 || i == 5 || i == 9) ? CH1_CTRL : CH1_DATA, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("[TB] FAIL eop_wrap_step%0d got=%h exp=%h", i, got, exp); end
            if (i == 1) repeat (2) tick();
            if (i == 2) repeat (3) tick();
            if (i == 4) tick();
        end
    endtask

    task automatic test_underrun();
        logic [31:0] got, exp;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0014_0000);
        exp_q.push_back(32'h0004_0000);
        for (int i = 0; i < 3; i++) begin
            bus_read((i == 0) ? CH0_DATA : CH0_CTRL, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("[TB] FAIL underrun_step%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_tx();
        logic [31:0] got, exp;
        int base;
        base = w_pulses;
        a_read = CH0_DATA; d_write = 32'hCAFE; w = 2'b11; #1;
        checks++;
        if (ram_w !== 2'b00 || dev_w !== 2'b00) begin failures++; $display("[TB] FAIL tx_data_write ram_w=%b dev_w=%b exp 00/00", ram_w, dev_w); end
        tick();
        a_read = CH0_CTRL; d_write = 32'h0012_0000; #1;
        checks++;
        if (dev_w !== 2'b01 || dev_din !== 32'hCAFE || dev_send_eop !== 2'b01) begin
            failures++; $display("[TB] FAIL tx_send dev_w=%b din=%h eop=%b exp 01/0000cafe/01", dev_w, dev_din, dev_send_eop);
        end
        tick();
        w = 2'b00; a_read = 32'h0; #1;
        checks++;
        if (dev_w !== 2'b00) begin failures++; $display("[TB] FAIL tx_one_cycle dev_w=%b exp 00", dev_w); end
        exp_q.push_back(32'h0000_0000);
        bus_read(CH0_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL tx_busy_status got=%h exp=%h", got, exp); end
        a_read = CH0_CTRL; d_write = 32'h0002_0000; w = 2'b11; #1;
        checks++;
        if (dev_w !== 2'b00 || dmem_wait !== 1'b0) begin failures++; $display("[TB] FAIL tx_drop dev_w=%b wait=%b exp 00/0", dev_w, dmem_wait); end
        tick();
        w = 2'b00; a_read = 32'h0;
        exp_q.push_back(32'h0020_0000);
        bus_read(CH0_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL tx_overrun_status got=%h exp=%h", got, exp); end
        dev_rdyw = 2'b01;
        tick();
        dev_rdyw = 2'b00;
        exp_q.push_back(32'h0004_0000);
        bus_read(CH0_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL tx_idle_status got=%h exp=%h", got, exp); end
        checks++;
        if (w_pulses - base !== 1) begin failures++; $display("[TB] FAIL tx_pulse_count got=%0d exp=1", w_pulses - base); end
    endtask

    task automatic test_blocking();
        logic [31:0] exp;
        do_reset();
        a_read = CH0_CTRL; d_write = 32'h0002_0000; w = 2'b11; #1;
        checks++;
        if (blk_dev_w !== 2'b01 || blk_wait !== 1'b0) begin failures++; $display("[TB] FAIL blk_first_send dev_w=%b wait=%b exp 01/0", blk_dev_w, blk_wait); end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (blk_wait !== 1'b1 || blk_dev_w !== 2'b00) begin failures++; $display("[TB] FAIL blk_send_stall%0d wait=%b dev_w=%b exp 1/00", i, blk_wait, blk_dev_w); end
            tick();
        end
        dev_rdyw = 2'b01; #1;
        checks++;
        if (blk_wait !== 1'b1) begin failures++; $display("[TB] FAIL blk_rdyw_busy wait=%b exp 1", blk_wait); end
        tick();
        dev_rdyw = 2'b00; #1;
        checks++;
        if (blk_wait !== 1'b0 || blk_dev_w !== 2'b01) begin failures++; $display("[TB] FAIL blk_send_release wait=%b dev_w=%b exp 0/01", blk_wait, blk_dev_w); end
        tick();
        w = 2'b00;
        a_read = CH0_DATA; r = 2'b01; #1;
        checks++;
        if (blk_wait !== 1'b1) begin failures++; $display("[TB] FAIL blk_read_empty wait=%b exp 1", blk_wait); end
        tick();
        rdyr0 = 1'b1; dout0 = 32'h55; #1;
        exp_q.push_back(32'h55);
        checks++;
        if (blk_wait !== 1'b1) begin failures++; $display("[TB] FAIL blk_push_same_cycle wait=%b exp 1", blk_wait); end
        tick();
        rdyr0 = 1'b0; #1;
        checks++;
        if (blk_wait !== 1'b0) begin failures++; $display("[TB] FAIL blk_read_release wait=%b exp 0", blk_wait); end
        tick();
        r = 2'b00; a_read_reg = CH0_DATA; a_read = 32'h0; #1;
        exp = exp_q.pop_front();
        checks++;
        if (blk_d_read !== exp) begin failures++; $display("[TB] FAIL blk_read_data got=%h exp=%h", blk_d_read, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        int base;
        do_reset();
        bus_write(CH0_CTRL, 32'h0002_0000);
        rdyr0 = 1'b1; dout0 = 32'h11;
        repeat (3) tick();
        rdyr0 = 1'b0;
        exp_q.push_back(32'h0301_0000);
        bus_read(CH0_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL pre_reset_status got=%h exp=%h", got, exp); end
        base = rst_act;
        rdyr0 = 1'b1; a_read = CH0_CTRL; d_write = 32'h0012_0000; w = 2'b11; reset = 1'b1;
        tick();
        checks++;
        if (dev_r !== 2'b00 || dev_w !== 2'b00) begin failures++; $display("[TB] FAIL reset_outputs dev_r=%b dev_w=%b exp 00/00", dev_r, dev_w); end
        tick();
        reset = 1'b0; w = 2'b00; rdyr0 = 1'b0; a_read = 32'h0;
        checks++;
        if (rst_act !== base) begin failures++; $display("[TB] FAIL reset_activity got=%0d exp=%0d", rst_act, base); end
        exp_q.push_back(32'h0004_0000);
        bus_read(CH0_CTRL, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL post_reset_status got=%h exp=%h", got, exp); end
    endtask

    initial begin
        reset = 1'b1; a_read = 32'h0; a_read_reg = 32'h0; d_write = 32'h0;
        w = 2'b00; r = 2'b00; ram_dout = 32'h0; ram_wait = 1'b0;
        dout0 = 32'h0; rdyr0 = 1'b0; dev_rdyw = 2'b00; ram_model = 32'h0;
        for (int i = 0; i < 32; i++) begin feed_words[i] = 32'h0; feed_eop[i] = 1'b0; end
        test_reset();
        test_ram();
        test_rx_prefetch();
        test_eop_wrap();
        test_underrun();
        test_tx();
        test_blocking();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
